// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin packet scheduler feeding one shared MAC input stage
// Optional MAC_SCHED_PRIO0_EN: requester 0 wins every arbitration it is valid for.
module mac_rr_scheduler #(
  parameter  int NREQ   = 4,
  parameter  int INT_A  = 6,
  parameter  int FRAC_A = 8,
  parameter  int INT_B  = 6,
  parameter  int FRAC_B = 8,
  localparam int DWA    = INT_A + FRAC_A,
  localparam int DWB    = INT_B + FRAC_B,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [NREQ*DWA-1:0] req_a_data,
  input  logic [NREQ*DWB-1:0] req_b_data,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [DWA-1:0]      mac_a,
  output logic [DWB-1:0]      mac_b,
  output logic                mac_valid,
  output logic                mac_last,
  output logic [IDW-1:0]      mac_id,
  input  logic                mac_ready,
  output logic                busy,
  output logic [15:0]         pkt_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DWA-1:0] mac_a_q, mac_a_d;
  logic [DWB-1:0] mac_b_q, mac_b_d;
  logic           mac_valid_q, mac_valid_d;
  logic           mac_last_q, mac_last_d;
  logic [IDW-1:0] mac_id_q, mac_id_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;

  logic           out_free;
  logic           accept;
  logic           found;
  logic [IDW-1:0] pick;
  int             idx;

  // The output register can take a new beat when empty or when being drained this cycle.
  assign out_free = !mac_valid_q || mac_ready;
  assign accept   = (state_q == BUSY) && req_valid[grant_q] && out_free;

  always_comb begin
    req_ready = '0;
    if (state_q == BUSY) req_ready[grant_q] = out_free;
  end

  // Scan rr_ptr+1 .. rr_ptr+NREQ (mod NREQ); the first valid requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
`ifdef MAC_SCHED_PRIO0_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_valid_d = mac_valid_q;
    mac_last_d  = mac_last_q;
    mac_id_d    = mac_id_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (accept) begin
      mac_a_d     = req_a_data[grant_q*DWA +: DWA];
      mac_b_d     = req_b_data[grant_q*DWB +: DWB];
      mac_last_d  = req_last[grant_q];
      mac_id_d    = grant_q;
      mac_valid_d = 1'b1;
    end else if (mac_ready) begin
      mac_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && req_last[grant_q]) begin
          state_d   = IDLE;
          rr_ptr_d  = grant_q;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IDW'(NREQ - 1);
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_id_q    <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_valid_q <= mac_valid_d;
      mac_last_q  <= mac_last_d;
      mac_id_q    <= mac_id_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_valid = mac_valid_q;
  assign mac_last  = mac_last_q;
  assign mac_id    = mac_id_q;
  assign busy      = (state_q == BUSY);
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb/tb_mac_rr_scheduler.sv - scoreboard bench for mac_rr_scheduler
module tb_mac_rr_scheduler;

  localparam int NREQ = 4;
  localparam int DWA  = 14;
  localparam int DWB  = 14;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DWA-1:0] a;
    logic [DWB-1:0] b;
    logic           last;
  } beat_t;

  logic                clock = 1'b0;
  logic                rst   = 1'b1;
  logic [NREQ*DWA-1:0] req_a_data = '0;
  logic [NREQ*DWB-1:0] req_b_data = '0;
  logic [NREQ-1:0]     req_valid  = '0;
  logic [NREQ-1:0]     req_last   = '0;
  logic [NREQ-1:0]     req_ready;
  logic [DWA-1:0]      mac_a;
  logic [DWB-1:0]      mac_b;
  logic                mac_valid;
  logic                mac_last;
  logic [IDW-1:0]      mac_id;
  logic                mac_ready  = 1'b1;
  logic                busy;
  logic [15:0]         pkt_cnt;

  beat_t rq [NREQ][$];
  beat_t sb [$];
  int    n_cmp = 0;
  int    n_err = 0;

  mac_rr_scheduler #(.NREQ(NREQ)) dut (
    .clock(clock), .rst(rst),
    .req_a_data(req_a_data), .req_b_data(req_b_data),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_last(mac_last),
    .mac_id(mac_id), .mac_ready(mac_ready), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue n beats on requester id; only the first nexp are expected at the MAC.
  task automatic push_pkt(input int id, input int n, input logic [DWA-1:0] a,
                          input logic [DWB-1:0] b0, input int nexp);
    beat_t bt;
    for (int k = 0; k < n; k++) begin
      bt.id   = IDW'(id);
      bt.a    = a;
      bt.b    = b0 + DWB'(k);
      bt.last = (k == n - 1);
      rq[id].push_back(bt);
      if (k < nexp) sb.push_back(bt);
    end
  endtask

  task automatic drain(input string nm);
    int c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(posedge clock);
      c++;
    end
    chk(nm, sb.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Requester model: holds each head beat until it is accepted.
  initial begin
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && !rst && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]              = 1'b1;
          req_a_data[i*DWA +: DWA]  = rq[i][0].a;
          req_b_data[i*DWB +: DWB]  = rq[i][0].b;
          req_last[i]               = rq[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: compares accepted MAC beats against the scoreboard and checks stall stability.
  initial begin
    beat_t exp_b;
    beat_t held;
    bit    stalled = 1'b0;
    forever begin
      @(negedge clock);
      if (rst || !mac_valid) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("stall_hold", {mac_id, mac_a, mac_b, mac_last}, held);
        if (mac_ready) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got id %0d a %0h b %0h, none expected", mac_id, mac_a, mac_b);
          end else begin
            exp_b = sb.pop_front();
            chk("beat_id", mac_id, exp_b.id);
            chk("beat_a", mac_a, exp_b.a);
            chk("beat_b", mac_b, exp_b.b);
            chk("beat_last", mac_last, exp_b.last);
          end
        end else begin
          chk("stall_ready", req_ready, 0);
          held    = {mac_id, mac_a, mac_b, mac_last};
          stalled = 1'b1;
        end
      end
    end
  end

  initial begin
    int c;
    // Reset with every requester valid: one single-beat packet of -1.0 each, order 0,1,2,3.
    for (int i = 0; i < NREQ; i++) push_pkt(i, 1, 14'h3F00, 14'h0100 + 14'(i), 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_valid", req_valid, 4'hF);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_mac_last", mac_last, 0);
    chk("rst_mac_id", mac_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    @(posedge clock);
    #1 rst = 1'b0;
    drain("drain_single");
    chk("pkt_cnt_single", pkt_cnt, 4);

    // Round-robin: rr_ptr=3, so requester 0 first, then 2.
    push_pkt(0, 3, 14'h0100, 14'h0200, 3);
    push_pkt(2, 3, 14'h0100, 14'h0210, 3);
    drain("drain_rr");
    chk("pkt_cnt_rr", pkt_cnt, 6);
    chk("idle_after_rr", busy, 0);

    // Backpressure mid-packet; rr_ptr=2 so scan 3,0 -> 0 then 2.
    push_pkt(0, 4, 14'h0123, 14'h0300, 4);
    push_pkt(2, 3, 14'h0456, 14'h0310, 3);
    c = 0;
    while (rq[0].size() > 2 && c < 100) begin
      @(posedge clock);
      #2;
      c++;
    end
    chk("bp_reach_mid", rq[0].size(), 2);
    mac_ready = 1'b0;
    repeat (4) @(posedge clock);
    #1 mac_ready = 1'b1;
    drain("drain_bp");
    chk("pkt_cnt_bp", pkt_cnt, 8);

    // Requesters 0 and 3 both valid repeatedly; rr_ptr=2.
`ifdef MAC_SCHED_PRIO0_EN
    push_pkt(0, 1, 14'h0010, 14'h0001, 1);
    push_pkt(0, 1, 14'h0011, 14'h0002, 1);
    push_pkt(3, 1, 14'h0030, 14'h0003, 1);
    push_pkt(3, 1, 14'h0031, 14'h0004, 1);
`else
    push_pkt(3, 1, 14'h0030, 14'h0003, 1);
    push_pkt(0, 1, 14'h0010, 14'h0001, 1);
    push_pkt(3, 1, 14'h0031, 14'h0004, 1);
    push_pkt(0, 1, 14'h0011, 14'h0002, 1);
`endif
    drain("drain_alt");
    chk("pkt_cnt_alt", pkt_cnt, 12);

    // Reset after beat 2 of a 5-beat packet from requester 1.
    push_pkt(1, 5, 14'h2ABC, 14'h1000, 2);
    c = 0;
    while (rq[1].size() > 3 && c < 100) begin
      @(posedge clock);
      #2;
      c++;
    end
    chk("mid_reach_beat2", rq[1].size(), 3);
    @(negedge clock);
    #1 rst = 1'b1;
    rq[1].delete();
    #1;
    chk("mid_rst_mac_valid", mac_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_sb_empty", sb.size(), 0);
    push_pkt(0, 1, 14'h0777, 14'h0001, 1);
    push_pkt(1, 1, 14'h0888, 14'h0002, 1);
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    drain("drain_after_rst");
    chk("pkt_cnt_after_rst", pkt_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
